div_arbiter: RTL and testbench

Shares one sequential restoring divider between the two rate computations of the bike computer: instantaneous speed (requested each `sec_pulse`) and average speed (requested after each speed result). It latches one pending request per requester, picks a winner, runs the divide, and returns the quotient to the owner with a one-cycle valid. It sits between the control FSM and the arithmetic datapath, replacing the ad-hoc `div_select` muxing.

---
 rtl/bike_pkg.sv | 19 +
 rtl/seq_div.sv | 55 +++++
 rtl/div_arbiter.sv | 176 +++++++++++++++++
 tb/tb_div_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// rtl/bike_pkg.sv - shared divider defaults and state/owner enums for the bike computer
package bike_pkg;

    localparam int DIV_DW = 24;
    localparam int DIV_VW = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } div_state_t;

    typedef enum logic {
        OWN_SPD,
        OWN_AVS
    } div_owner_t;

endpackage

// File: rtl/seq_div.sv
// rtl/seq_div.sv - restoring divider, one quotient bit per cycle MSB first after load
module seq_div
    import bike_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] r_acc;
    logic [VW:0]   r_rem;
    logic [VW-1:0] r_divisor;
    logic [CW-1:0] r_count;
    logic [VW+1:0] w_shift;
    logic [VW+1:0] w_diff;

    // Dividend bits shift out of r_acc's MSB while quotient bits shift in at its LSB.
    assign w_shift  = {r_rem, r_acc[DW-1]};
    assign w_diff   = w_shift - {2'b00, r_divisor};
    assign done     = (r_count == CW'(DW));
    assign quotient = r_acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_count   <= CW'(DW);
        end else if (load) begin
            r_acc     <= dividend;
            r_rem     <= '0;
            r_divisor <= divisor;
            r_count   <= '0;
        end else if (!done) begin
            r_count <= r_count + CW'(1);
            if (!w_diff[VW+1]) begin
                r_rem <= w_diff[VW:0];
                r_acc <= {r_acc[DW-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[VW:0];
                r_acc <= {r_acc[DW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - shares seq_div between speed and avg-speed requesters; DIV_ARB_RR_EN selects round-robin
module div_arbiter
    import bike_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          spd_req,
    input  logic [DW-1:0] spd_dividend,
    input  logic [VW-1:0] spd_divisor,
    output logic          spd_ack,
    output logic          spd_valid,
    output logic [DW-1:0] spd_quotient,
    input  logic          avs_req,
    input  logic [DW-1:0] avs_dividend,
    input  logic [VW-1:0] avs_divisor,
    output logic          avs_ack,
    output logic          avs_valid,
    output logic [DW-1:0] avs_quotient,
    output logic          busy,
    output logic          owner,
    output logic          div_by_zero,
    output logic          overrun
);

    div_state_t    r_state;
    div_state_t    w_next;
    div_owner_t    r_owner;
    div_owner_t    w_win;
    logic          r_spd_pend;
    logic          r_avs_pend;
    logic [DW-1:0] r_spd_dd;
    logic [VW-1:0] r_spd_dv;
    logic [DW-1:0] r_avs_dd;
    logic [VW-1:0] r_avs_dv;
    logic          r_dz;
    logic [DW-1:0] r_spd_q;
    logic [DW-1:0] r_avs_q;
    logic          w_grant;
    logic          w_capture;
    logic          w_grant_spd;
    logic          w_grant_avs;
    logic [DW-1:0] w_ld_dd;
    logic [VW-1:0] w_ld_dv;
    logic          w_div_done;
    logic [DW-1:0] w_div_q;
    logic [DW-1:0] w_result;
`ifdef DIV_ARB_RR_EN
    div_owner_t    r_last;
`endif

    always_comb begin
        w_win = r_spd_pend ? OWN_SPD : OWN_AVS;
`ifdef DIV_ARB_RR_EN
        if (r_spd_pend && r_avs_pend) begin
            w_win = (r_last == OWN_SPD) ? OWN_AVS : OWN_SPD;
        end
`endif
    end

    assign w_grant_spd = w_grant && (w_win == OWN_SPD);
    assign w_grant_avs = w_grant && (w_win == OWN_AVS);
    assign w_ld_dd     = (w_win == OWN_SPD) ? r_spd_dd : r_avs_dd;
    assign w_ld_dv     = (w_win == OWN_SPD) ? r_spd_dv : r_avs_dv;
    assign w_result    = r_dz ? {DW{1'b1}} : w_div_q;

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        spd_ack     = 1'b0;
        avs_ack     = 1'b0;
        spd_valid   = 1'b0;
        avs_valid   = 1'b0;
        div_by_zero = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_spd_pend || r_avs_pend) begin
                    w_grant = 1'b1;
                    w_next  = LOAD;
                end
            end
            LOAD: begin
                spd_ack = (r_owner == OWN_SPD);
                avs_ack = (r_owner == OWN_AVS);
                if (r_dz) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_div_done) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end
            end
            DONE: begin
                spd_valid   = (r_owner == OWN_SPD);
                avs_valid   = (r_owner == OWN_AVS);
                div_by_zero = r_dz;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A request landing on the edge that clears its own flag re-arms it without counting as overrun.
    assign overrun = (spd_req && r_spd_pend && !w_grant_spd) ||
                     (avs_req && r_avs_pend && !w_grant_avs);
    assign busy         = (r_state != IDLE);
    assign owner        = r_owner;
    assign spd_quotient = r_spd_q;
    assign avs_quotient = r_avs_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= OWN_SPD;
            r_spd_pend <= 1'b0;
            r_avs_pend <= 1'b0;
            r_spd_dd   <= '0;
            r_spd_dv   <= '0;
            r_avs_dd   <= '0;
            r_avs_dv   <= '0;
            r_dz       <= 1'b0;
            r_spd_q    <= '0;
            r_avs_q    <= '0;
`ifdef DIV_ARB_RR_EN
            r_last     <= OWN_AVS;
`endif
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_win;
                r_dz    <= (w_ld_dv == '0);
`ifdef DIV_ARB_RR_EN
                r_last  <= w_win;
`endif
            end
            if (spd_req) begin
                r_spd_pend <= 1'b1;
                r_spd_dd   <= spd_dividend;
                r_spd_dv   <= spd_divisor;
            end else if (w_grant_spd) begin
                r_spd_pend <= 1'b0;
            end
            if (avs_req) begin
                r_avs_pend <= 1'b1;
                r_avs_dd   <= avs_dividend;
                r_avs_dv   <= avs_divisor;
            end else if (w_grant_avs) begin
                r_avs_pend <= 1'b0;
            end
            if (w_capture && (r_owner == OWN_SPD)) r_spd_q <= w_result;
            if (w_capture && (r_owner == OWN_AVS)) r_avs_q <= w_result;
        end
    end

    seq_div #(
        .DW(DW),
        .VW(VW)
    ) u_seq_div (
        .clock   (clock),
        .reset   (reset),
        .load    (w_grant),
        .dividend(w_ld_dd),
        .divisor (w_ld_dv),
        .done    (w_div_done),
        .quotient(w_div_q)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed and randomized checks of div_arbiter against an arithmetic model
module tb_div_arbiter;
    import bike_pkg::*;

    localparam int DW = DIV_DW;
    localparam int VW = DIV_VW;
`ifdef DIV_ARB_RR_EN
    localparam int RR_MODE = 1;
`else
    localparam int RR_MODE = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          spd_req = 1'b0;
    logic [DW-1:0] spd_dividend = '0;
    logic [VW-1:0] spd_divisor = '0;
    logic          spd_ack;
    logic          spd_valid;
    logic [DW-1:0] spd_quotient;
    logic          avs_req = 1'b0;
    logic [DW-1:0] avs_dividend = '0;
    logic [VW-1:0] avs_divisor = '0;
    logic          avs_ack;
    logic          avs_valid;
    logic [DW-1:0] avs_quotient;
    logic          busy;
    logic          owner;
    logic          div_by_zero;
    logic          overrun;

    div_arbiter #(.DW(DW), .VW(VW)) dut (
        .clock       (clock),
        .reset       (reset),
        .spd_req     (spd_req),
        .spd_dividend(spd_dividend),
        .spd_divisor (spd_divisor),
        .spd_ack     (spd_ack),
        .spd_valid   (spd_valid),
        .spd_quotient(spd_quotient),
        .avs_req     (avs_req),
        .avs_dividend(avs_dividend),
        .avs_divisor (avs_divisor),
        .avs_ack     (avs_ack),
        .avs_valid   (avs_valid),
        .avs_quotient(avs_quotient),
        .busy        (busy),
        .owner       (owner),
        .div_by_zero (div_by_zero),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_spd_ack = 0, n_spd_valid = 0, n_avs_ack = 0, n_avs_valid = 0, n_dz = 0, n_ovr = 0;
    int c_spd_ack = 0, c_spd_valid = 0, c_avs_ack = 0, c_avs_valid = 0, c_dz = 0;

    // Event log sampled mid-cycle; the stimulus thread only reads these counters.
    always @(negedge clock) begin
        if (spd_ack)     begin n_spd_ack   <= n_spd_ack + 1;   c_spd_ack   <= cyc; end
        if (spd_valid)   begin n_spd_valid <= n_spd_valid + 1; c_spd_valid <= cyc; end
        if (avs_ack)     begin n_avs_ack   <= n_avs_ack + 1;   c_avs_ack   <= cyc; end
        if (avs_valid)   begin n_avs_valid <= n_avs_valid + 1; c_avs_valid <= cyc; end
        if (div_by_zero) begin n_dz        <= n_dz + 1;        c_dz        <= cyc; end
        if (overrun) n_ovr <= n_ovr + 1;
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
        if (b == 0) return {DW{1'b1}};
        return a / DW'(b);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        spd_req = 1'b0;
        avs_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    int t0, b0, b1, b2, b3;
    logic [DW-1:0] dd, dd2;
    logic [VW-1:0] dv, dv2;
    bit            sel;

    initial begin
        #1;
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_spd_q", 32'(spd_quotient), 0);
        chk("rst_avs_q", 32'(avs_quotient), 0);
        chk("rst_valid", 32'({spd_valid, avs_valid, spd_ack, avs_ack, div_by_zero, overrun}), 0);

        // single speed request
        b0 = n_spd_valid; b1 = n_avs_valid;
        t0 = cyc; spd_req = 1; spd_dividend = 1000; spd_divisor = 7; step(); spd_req = 0;
        for (int i = 0; i < 40 && n_spd_valid == b0; i++) step();
        chk("t1_nvalid", 32'(n_spd_valid - b0), 1);
        chk("t1_ack_cyc", 32'(c_spd_ack - t0), 2);
        chk("t1_valid_cyc", 32'(c_spd_valid - t0), 27);
        chk("t1_q", 32'(spd_quotient), 32'(ref_div(1000, 7)));
        chk("t1_no_avs", 32'(n_avs_valid - b1), 0);

        // simultaneous requests, speed first after reset
        do_reset();
        b1 = n_avs_valid;
        t0 = cyc;
        spd_req = 1; spd_dividend = 100; spd_divisor = 10;
        avs_req = 1; avs_dividend = 90;  avs_divisor = 9;
        step(); spd_req = 0; avs_req = 0;
        for (int i = 0; i < 80 && n_avs_valid == b1; i++) step();
        chk("t2_spd_valid_cyc", 32'(c_spd_valid - t0), 27);
        chk("t2_avs_ack_cyc", 32'(c_avs_ack - t0), 29);
        chk("t2_avs_valid_cyc", 32'(c_avs_valid - t0), 54);
        chk("t2_spd_q", 32'(spd_quotient), 32'(ref_div(100, 10)));
        chk("t2_avs_q", 32'(avs_quotient), 32'(ref_div(90, 9)));

        // divide by zero
        b1 = n_avs_valid; b2 = n_dz;
        t0 = cyc; avs_req = 1; avs_dividend = 500; avs_divisor = 0; step(); avs_req = 0;
        for (int i = 0; i < 20 && n_avs_valid == b1; i++) step();
        chk("t3_valid_cyc", 32'(c_avs_valid - t0), 3);
        chk("t3_dz_cyc", 32'(c_dz - t0), 3);
        chk("t3_ndz", 32'(n_dz - b2), 1);
        chk("t3_q", 32'(avs_quotient), 32'(ref_div(500, 0)));

        // re-request on the grant edge: set wins, old operands used, no overrun
        b0 = n_spd_valid; b3 = n_ovr;
        t0 = cyc;
        spd_req = 1; spd_dividend = 1000; spd_divisor = 7; step();
        spd_dividend = 300; spd_divisor = 3; step(); spd_req = 0;
        for (int i = 0; i < 40 && n_spd_valid == b0; i++) step();
        chk("t4_first_q", 32'(spd_quotient), 32'(ref_div(1000, 7)));
        for (int i = 0; i < 40 && n_spd_valid == b0 + 1; i++) step();
        chk("t4_second_q", 32'(spd_quotient), 32'(ref_div(300, 3)));
        chk("t4_second_cyc", 32'(c_spd_valid - t0), 54);
        chk("t4_no_ovr", 32'(n_ovr - b3), 0);

        // overrun while avs runs
        do_reset();
        b0 = n_spd_valid; b3 = n_ovr; b1 = n_avs_valid;
        dd = DW'($urandom); dv = VW'($urandom_range(1, 65535));
        t0 = cyc; avs_req = 1; avs_dividend = dd; avs_divisor = dv; step(); avs_req = 0;
        for (int i = 0; i < 4; i++) step();
        spd_req = 1; spd_dividend = 40; spd_divisor = 4; step(); spd_req = 0;
        step(); step();
        spd_req = 1; spd_dividend = 80; spd_divisor = 4; step(); spd_req = 0;
        for (int i = 0; i < 90 && n_spd_valid == b0; i++) step();
        chk("t5_ovr", 32'(n_ovr - b3), 1);
        chk("t5_spd_q", 32'(spd_quotient), 32'(ref_div(80, 4)));
        chk("t5_avs_q", 32'(avs_quotient), 32'(ref_div(dd, dv)));
        chk("t5_avs_nvalid", 32'(n_avs_valid - b1), 1);

        // reset in cycle 10 of a running divide with avs pending
        b0 = n_spd_valid; b1 = n_avs_valid; b2 = n_avs_ack;
        t0 = cyc; spd_req = 1; spd_dividend = DW'($urandom); spd_divisor = 16'd3; step(); spd_req = 0;
        step(); step();
        avs_req = 1; avs_dividend = 77; avs_divisor = 7; step(); avs_req = 0;
        while (cyc - t0 < 10) step();
        reset = 1; step(); reset = 0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_spd_q", 32'(spd_quotient), 0);
        chk("t6_avs_q", 32'(avs_quotient), 0);
        for (int i = 0; i < 60; i++) step();
        chk("t6_no_spd_valid", 32'(n_spd_valid - b0), 0);
        chk("t6_no_avs_ack", 32'(n_avs_ack - b2), 0);
        chk("t6_no_avs_valid", 32'(n_avs_valid - b1), 0);

        // speed re-requests every DONE; avs must wait unless round-robin
        do_reset();
        b1 = n_avs_valid; b2 = n_avs_ack;
        t0 = cyc; spd_req = 1; spd_dividend = DW'($urandom); spd_divisor = 16'd9; step(); spd_req = 0;
        dd = DW'($urandom); dv = VW'($urandom_range(1, 300));
        avs_req = 1; avs_dividend = dd; avs_divisor = dv; step(); avs_req = 0;
        for (int i = 0; i < 90; i++) begin
            spd_req = spd_valid;
            spd_dividend = DW'($urandom);
            step();
        end
        spd_req = 0;
        chk("t7_avs_acks", 32'(n_avs_ack - b2), 32'(RR_MODE));
        for (int i = 0; i < 150 && n_avs_valid == b1; i++) step();
        chk("t7_avs_done", 32'(n_avs_valid - b1), 1);
        chk("t7_avs_q", 32'(avs_quotient), 32'(ref_div(dd, dv)));

        // randomized single requests against the arithmetic model
        for (int k = 0; k < 12; k++) begin
            sel = 1'($urandom_range(0, 1));
            dd2 = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       dv2 = '0;
                1:       dv2 = VW'($urandom_range(1, 20));
                default: dv2 = VW'($urandom);
            endcase
            b0 = sel ? n_avs_valid : n_spd_valid;
            b2 = n_dz;
            t0 = cyc;
            if (sel) begin
                avs_req = 1; avs_dividend = dd2; avs_divisor = dv2;
            end else begin
                spd_req = 1; spd_dividend = dd2; spd_divisor = dv2;
            end
            step(); avs_req = 0; spd_req = 0;
            for (int i = 0; i < 40 && (sel ? n_avs_valid : n_spd_valid) == b0; i++) step();
            chk("rnd_nvalid", 32'((sel ? n_avs_valid : n_spd_valid) - b0), 1);
            chk("rnd_latency", 32'((sel ? c_avs_valid : c_spd_valid) - t0), (dv2 == 0) ? 3 : 27);
            chk("rnd_q", 32'(sel ? avs_quotient : spd_quotient), 32'(ref_div(dd2, dv2)));
            chk("rnd_dz", 32'(n_dz - b2), (dv2 == 0) ? 1 : 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
